// File: rtl/imem_pkg.sv
// Shared types and widths for the program loader and its instruction store.
package imem_pkg;

  localparam int         WORD_W       = 16;
  localparam int         ADDR_W       = 8;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_CSUM,
    ST_CHECK,
    ST_RUN
  } state_e;

endpackage

// File: rtl/imem_ram.sv
// Instruction store: one synchronous write port, one asynchronous read port.
// A same-cycle read of the address being written returns the old word.
module imem_ram
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WORD_W-1:0]     wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WORD_W-1:0]     rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader; holds the CPU in reset until a checksummed image lands.
// Verdict reaches load_done/cpu_reset two edges after the CSUM byte; rx_ready drops only in CHECK.
module imem_loader
  import imem_pkg::*;
#(
  parameter int          ADDR_WIDTH     = ADDR_W,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [WORD_W-1:0]     fetch_data,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [8:0]            cnt_q, cnt_d;
  logic [7:0]            lo_q, lo_d;
  logic [7:0]            sum_q, sum_d;
  logic [15:0]           timer_q, timer_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  load_done_q, load_done_d;
  logic                  load_error_q, load_error_d;
  logic                  pass_pend_q, pass_pend_d;
  logic                  fail_pend_q, fail_pend_d;
  logic                  accept, is_sync, in_frame, timed_out, mem_we;

  assign rx_ready  = (state_q != ST_CHECK);
  assign accept    = rx_valid && rx_ready;
  assign is_sync   = (rx_data == SYNC_BYTE);
  assign in_frame  = (state_q == ST_LEN) || (state_q == ST_DATA_LO) ||
                     (state_q == ST_DATA_HI) || (state_q == ST_CSUM);
  assign timed_out = in_frame && !accept && ((timer_q + 16'd1) == TIMEOUT_CYCLES);
  assign mem_we    = (state_q == ST_DATA_HI) && accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept && is_sync) state_d = ST_LEN;
      ST_LEN:     if (accept) state_d = ST_DATA_LO;
      ST_DATA_LO: if (accept) state_d = ST_DATA_HI;
      ST_DATA_HI: if (accept) state_d = (cnt_q == 9'd1) ? ST_CSUM : ST_DATA_LO;
      ST_CSUM:    if (accept) state_d = ST_CHECK;
      ST_CHECK:   state_d = (sum_q == 8'd0) ? ST_RUN : ST_IDLE;
      ST_RUN:     if (accept && is_sync) state_d = ST_LEN;
      default:    state_d = ST_IDLE;
    endcase
    if (timed_out) state_d = ST_IDLE;
  end

  always_comb begin
    wr_addr_d    = wr_addr_q;
    cnt_d        = cnt_q;
    lo_d         = lo_q;
    sum_d        = sum_q;
    timer_d      = 16'd0;
    cpu_reset_d  = cpu_reset_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
    pass_pend_d  = 1'b0;
    fail_pend_d  = 1'b0;

    // The verdict is taken in CHECK and lands on the outputs one edge later.
    if (pass_pend_q) begin
      load_done_d = 1'b1;
      cpu_reset_d = 1'b0;
    end
    if (fail_pend_q) begin
      load_error_d = 1'b1;
      cpu_reset_d  = 1'b1;
    end

    if (in_frame && !accept) timer_d = timer_q + 16'd1;
    if (timed_out) begin
      timer_d      = 16'd0;
      load_error_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: if (accept && is_sync) begin
        cpu_reset_d  = 1'b1;
        load_done_d  = 1'b0;
        load_error_d = 1'b0;
      end
      ST_LEN: if (accept) begin
        cnt_d     = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
        sum_d     = rx_data;
        wr_addr_d = '0;
      end
      ST_DATA_LO: if (accept) begin
        lo_d  = rx_data;
        sum_d = sum_q + rx_data;
      end
      ST_DATA_HI: if (accept) begin
        wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
        cnt_d     = cnt_q - 9'd1;
        sum_d     = sum_q + rx_data;
      end
      ST_CSUM: if (accept) sum_d = sum_q + rx_data;
      ST_CHECK: begin
        pass_pend_d = (sum_q == 8'd0);
        fail_pend_d = (sum_q != 8'd0);
      end
      ST_RUN: if (accept && is_sync) begin
        cpu_reset_d = 1'b1;
        load_done_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr_q    <= '0;
      cnt_q        <= 9'd0;
      lo_q         <= 8'd0;
      sum_q        <= 8'd0;
      timer_q      <= 16'd0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      pass_pend_q  <= 1'b0;
      fail_pend_q  <= 1'b0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      cnt_q        <= cnt_d;
      lo_q         <= lo_d;
      sum_q        <= sum_d;
      timer_q      <= timer_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
      pass_pend_q  <= pass_pend_d;
      fail_pend_q  <= fail_pend_d;
    end
  end

  assign cpu_reset  = cpu_reset_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

  imem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_addr_q),
    .wdata_i ({rx_data, lo_q}),
    .raddr_i (fetch_addr),
    .rdata_o (fetch_data)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; expected memory words are queued as bytes are sent.
module tb_imem_loader;
  import imem_pkg::*;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [7:0]  fetch_addr;
  logic [15:0] fetch_data;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb[$];

  imem_loader #(.TIMEOUT_CYCLES(16'd16)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!rx_ready && n < 8) begin
      tick();
      n++;
    end
    chk("rx_ready_wait", 32'(rx_ready), 32'd1);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] addr);
    logic [15:0] exp;
    fetch_addr = addr;
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty observed=%0h", tag, fetch_data);
    end else begin
      exp = sb.pop_front();
      chk(tag, 32'(fetch_data), 32'(exp));
    end
  endtask

  initial begin
    reset      = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    fetch_addr = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_error", 32'(load_error), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);

    // Junk then a good two-word frame
    send_byte(8'h11);
    send_byte(8'h22);
    chk("junk_idle", 32'(dut.state_q), 32'(ST_IDLE));
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h05); sb.push_back(16'h0501);
    send_byte(8'h03); send_byte(8'h00); sb.push_back(16'h0003);
    send_byte(8'hF5);
    chk("good_t_done", 32'(load_done), 32'd0);
    tick();
    chk("good_t1_done", 32'(load_done), 32'd0);
    chk("good_t1_cpurst", 32'(cpu_reset), 32'd1);
    tick();
    chk("good_t2_done", 32'(load_done), 32'd1);
    chk("good_t2_cpurst", 32'(cpu_reset), 32'd0);
    chk("good_t2_err", 32'(load_error), 32'd0);
    read_chk("good_mem0", 8'd0);
    read_chk("good_mem1", 8'd1);

    // Restart from RUN with a bad checksum
    send_byte(8'hA5);
    chk("restart_cpurst", 32'(cpu_reset), 32'd1);
    chk("restart_done", 32'(load_done), 32'd0);
    send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h05);
    send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h00);
    tick();
    tick();
    chk("bad_err", 32'(load_error), 32'd1);
    chk("bad_cpurst", 32'(cpu_reset), 32'd1);
    chk("bad_done", 32'(load_done), 32'd0);
    chk("bad_idle", 32'(dut.state_q), 32'(ST_IDLE));
    send_byte(8'hA5);
    chk("bad_err_cleared", 32'(load_error), 32'd0);

    // Timeout after 16 idle cycles inside a frame
    send_byte(8'h01);
    send_byte(8'h07);
    for (int i = 0; i < 15; i++) tick();
    chk("to_15_err", 32'(load_error), 32'd0);
    chk("to_15_state", 32'(dut.state_q), 32'(ST_DATA_HI));
    tick();
    chk("to_16_err", 32'(load_error), 32'd1);
    chk("to_16_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("to_16_cpurst", 32'(cpu_reset), 32'd1);

    // Good load, then restart and reset mid-DATA_HI
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h05);
    send_byte(8'h03); send_byte(8'h00);
    send_byte(8'hF5);
    tick();
    tick();
    chk("run_cpurst", 32'(cpu_reset), 32'd0);
    send_byte(8'hA5);
    chk("run_sync_cpurst", 32'(cpu_reset), 32'd1);
    send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB); sb.push_back(16'hBBAA);
    send_byte(8'hCC);
    chk("mid_state", 32'(dut.state_q), 32'(ST_DATA_HI));
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("mid_rst_cpurst", 32'(cpu_reset), 32'd1);
    chk("mid_rst_wraddr", 32'(dut.wr_addr_q), 32'd0);
    sb.push_back(16'h0003);
    read_chk("mid_mem0", 8'd0);
    read_chk("mid_mem1", 8'd1);
    tick();

    // LEN=0: 256 words {i,i}; payload sums to 0 mod 256 so CSUM is 00
    send_byte(8'hA5);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i));
      send_byte(8'(i));
      sb.push_back({8'(i), 8'(i)});
    end
    chk("full_wraddr_wrap", 32'(dut.wr_addr_q), 32'd0);
    chk("full_state_csum", 32'(dut.state_q), 32'(ST_CSUM));
    send_byte(8'h00);
    tick();
    tick();
    chk("full_done", 32'(load_done), 32'd1);
    chk("full_cpurst", 32'(cpu_reset), 32'd0);
    for (int i = 0; i < 256; i++) read_chk("full_mem", 8'(i));
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
